// File: rtl/eem16_proj3_pkg.sv
// Shared constants and state type for the gum vending controller.
package eem16_proj3_pkg;

  // Coin codes as presented on {x1, x0}; 2'b10 is invalid and treated as no coin.
  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_NICKEL = 2'b01;
  localparam logic [1:0] COIN_DIME   = 2'b11;

  localparam int unsigned PRICE_CENTS = 20;

  // Credit held toward the gum price.
  typedef enum logic [1:0] {
    C0  = 2'b00,
    C5  = 2'b01,
    C10 = 2'b10,
    C15 = 2'b11
  } state_t;

endpackage

// File: rtl/eem16_proj3_next.sv
// Combinational next-state and vend/change decode for the gum vending controller.
module eem16_proj3_next
  import eem16_proj3_pkg::*;
(
  input  state_t     state,
  input  logic       x1,
  input  logic       x0,
  output state_t     state_nxt,
  output logic       rg_nxt,
  output logic       rn_nxt
);

  logic [1:0] coin;
  logic       nickel;
  logic       dime;

  assign coin   = {x1, x0};
  assign nickel = (coin == COIN_NICKEL);
  assign dime   = (coin == COIN_DIME);

  // Transition table; a price of 20 is reached from C15+N, C10+D, and exceeded by C15+D.
  always_comb begin
    state_nxt = state;
    rg_nxt    = 1'b0;
    rn_nxt    = 1'b0;
    unique case (state)
      C0: begin
        if (nickel)    state_nxt = C5;
        else if (dime) state_nxt = C10;
      end
      C5: begin
        if (nickel)    state_nxt = C10;
        else if (dime) state_nxt = C15;
      end
      C10: begin
        if (nickel) begin
          state_nxt = C15;
        end else if (dime) begin
          state_nxt = C0;
          rg_nxt    = 1'b1;
        end
      end
      C15: begin
        if (nickel || dime) begin
          state_nxt = C0;
          rg_nxt    = 1'b1;
          rn_nxt    = dime;  // 25 cents paid, one nickel back
        end
      end
      // Unknown encoding falls back to idle with no pulses.
      default: begin
        state_nxt = C0;
      end
    endcase
  end

endmodule

// File: rtl/eem16_proj3.sv
// Gum vending controller top: credit state register plus registered RG/RN pulses.
module eem16_proj3
  import eem16_proj3_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic x1,
  input  logic x0,
  output logic RG,
  output logic RN
);

  state_t state_q;
  state_t state_d;
  logic   rg_q;
  logic   rg_d;
  logic   rn_q;
  logic   rn_d;

  eem16_proj3_next u_next (
    .state     (state_q),
    .x1        (x1),
    .x0        (x0),
    .state_nxt (state_d),
    .rg_nxt    (rg_d),
    .rn_nxt    (rn_d)
  );

  // Credit state register; reset discards partial credit without change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= C0;
    end else begin
      state_q <= state_d;
    end
  end

  // Output flops: each pulse lasts exactly the cycle following the completing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rg_q <= 1'b0;
      rn_q <= 1'b0;
    end else begin
      rg_q <= rg_d;
      rn_q <= rn_d;
    end
  end

  // Actuator outputs come straight from the flops.
  always_comb begin
    RG = rg_q;
    RN = rn_q;
  end

endmodule

// File: tb/tb_eem16_proj3.sv
// Scoreboard bench for the gum vending controller.
module tb_eem16_proj3;
  import eem16_proj3_pkg::*;

  logic clk;
  logic reset;
  logic x1;
  logic x0;
  logic RG;
  logic RN;

  eem16_proj3 dut (
    .clk   (clk),
    .reset (reset),
    .x1    (x1),
    .x0    (x0),
    .RG    (RG),
    .RN    (RN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] exp;  // {RG, RN}
  } item_t;

  item_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got RG,RN=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_state(input string name);
    n_cmp++;
    if (dut.state_q !== C0) begin
      n_bad++;
      $display("FAIL %s: got state=%b required %b at %0t", name, dut.state_q, C0, $time);
    end
  endtask

  // Drive one coin code for the coming edge and queue the expected pulses for that edge.
  task automatic apply(input string name, input logic [1:0] code, input logic rg, input logic rn);
    item_t it;
    @(negedge clk);
    {x1, x0} = code;
    it.name = name;
    it.exp  = {rg, rn};
    sb.push_back(it);
  endtask

  // Monitor: after every rising edge, compare outputs against the oldest queued expectation.
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        it = sb.pop_front();
        check(it.name, {RG, RN}, it.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    // Power-up: reset asynchronously clears outputs; a dime during reset is ignored.
    reset = 1'b1;
    {x1, x0} = COIN_DIME;
    #1;
    check("por_async", {RG, RN}, 2'b00);
    check_idle_state("por_state");
    @(posedge clk);
    #1;
    check("por_held", {RG, RN}, 2'b00);
    check_idle_state("por_held_state");
    @(negedge clk);
    {x1, x0} = COIN_NONE;
    reset = 1'b0;

    apply("idle0", COIN_NONE, 1'b0, 1'b0);
    apply("idle1", COIN_NONE, 1'b0, 1'b0);

    // D, N, D: 25 cents -> gum plus one nickel.
    apply("dnd_d1", COIN_DIME,   1'b0, 1'b0);
    apply("dnd_n",  COIN_NICKEL, 1'b0, 1'b0);
    apply("dnd_d2", COIN_DIME,   1'b1, 1'b1);
    apply("dnd_clr", COIN_NONE,  1'b0, 1'b0);

    // Four nickels: exact price.
    apply("nnnn_1", COIN_NICKEL, 1'b0, 1'b0);
    apply("nnnn_2", COIN_NICKEL, 1'b0, 1'b0);
    apply("nnnn_3", COIN_NICKEL, 1'b0, 1'b0);
    apply("nnnn_4", COIN_NICKEL, 1'b1, 1'b0);
    apply("nnnn_clr", COIN_NONE, 1'b0, 1'b0);

    // Nickel then a reset pulse shorter than a clock period discards the credit.
    apply("rst_n",    COIN_NICKEL, 1'b0, 1'b0);
    apply("rst_idle", COIN_NONE,   1'b0, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_pulse", {RG, RN}, 2'b00);
    check_idle_state("rst_pulse_state");
    #1;
    reset = 1'b0;
    apply("rst_d1", COIN_DIME, 1'b0, 1'b0);
    apply("rst_d2", COIN_DIME, 1'b1, 1'b0);
    apply("rst_clr", COIN_NONE, 1'b0, 1'b0);

    // Invalid and idle codes interleaved leave credit untouched.
    apply("inv_n1",  COIN_NICKEL, 1'b0, 1'b0);
    apply("inv_10a", 2'b10,       1'b0, 1'b0);
    apply("inv_00",  COIN_NONE,   1'b0, 1'b0);
    apply("inv_d",   COIN_DIME,   1'b0, 1'b0);
    apply("inv_10b", 2'b10,       1'b0, 1'b0);
    apply("inv_n2",  COIN_NICKEL, 1'b1, 1'b0);
    apply("inv_clr", COIN_NONE,   1'b0, 1'b0);

    // Back-to-back dimes: a vend every second edge, no change.
    apply("b2b_1", COIN_DIME, 1'b0, 1'b0);
    apply("b2b_2", COIN_DIME, 1'b1, 1'b0);
    apply("b2b_3", COIN_DIME, 1'b0, 1'b0);
    apply("b2b_4", COIN_DIME, 1'b1, 1'b0);

    // N, D, N: C5 + D -> C15, then a nickel completes exactly.
    apply("ndn_n1", COIN_NICKEL, 1'b0, 1'b0);
    apply("ndn_d",  COIN_DIME,   1'b0, 1'b0);
    apply("ndn_n2", COIN_NICKEL, 1'b1, 1'b0);
    apply("end_idle", COIN_NONE, 1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    guard = 0;
    while (sb.size() != 0 && guard < 10) begin
      @(posedge clk);
      #2;
      guard++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending required 0", sb.size());
    end
    check_idle_state("end_state");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
